// File: rtl/hex_history_display.sv
// hex_history_display
// Four-digit common-anode seven-segment display stage. Keeps the last four
// distinct nibbles seen on value_in (newest on digit 0) and time-multiplexes
// the digits with a programmable prescaler. All outputs are registered.
module hex_history_display #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] value_in,
  input  logic       hold,
  input  logic       clear,
  output logic [6:0] seg_n,
  output logic [3:0] an_n,
  output logic       dp_n,
  output logic       shift_p
);

  // Prescaler width: enough bits to hold SCAN_DIV-1 (SCAN_DIV is at least 2).
  localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Hex glyph for one nibble, segments {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'b1000000;
      4'h1:    g = 7'b1111001;
      4'h2:    g = 7'b0100100;
      4'h3:    g = 7'b0110000;
      4'h4:    g = 7'b0011001;
      4'h5:    g = 7'b0010010;
      4'h6:    g = 7'b0000010;
      4'h7:    g = 7'b1111000;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0010000;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b0000011;
      4'hC:    g = 7'b1000110;
      4'hD:    g = 7'b0100001;
      4'hE:    g = 7'b0000110;
      4'hF:    g = 7'b0001110;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

  // State: hist_q[0] is the newest entry.
  logic [3:0]       prev_q;
  logic [3:0][3:0]  hist_q,  hist_d;
  logic [2:0]       cnt_q,   cnt_d;
  logic [PRE_W-1:0] pre_q,   pre_d;
  logic [1:0]       idx_q,   idx_d;

  // Registered outputs.
  logic [6:0] seg_n_q,   seg_n_d;
  logic [3:0] an_n_q,    an_n_d;
  logic       dp_n_q,    dp_n_d;
  logic       shift_p_q, shift_p_d;

  logic change_s;

  // History update: clear beats a change; changes during hold are dropped.
  always_comb begin
    hist_d    = hist_q;
    cnt_d     = cnt_q;
    shift_p_d = 1'b0;
    change_s  = (value_in != prev_q);
    if (clear) begin
      hist_d = '0;
      cnt_d  = 3'd0;
    end else if (change_s && !hold) begin
      hist_d    = {hist_q[2], hist_q[1], hist_q[0], value_in};
      cnt_d     = (cnt_q >= 3'd4) ? 3'd4 : (cnt_q + 3'd1);
      shift_p_d = 1'b1;
    end else begin
      hist_d    = hist_q;
      cnt_d     = cnt_q;
      shift_p_d = 1'b0;
    end
  end

  // Scan prescaler and digit index; the digit advances when the prescaler wraps.
  always_comb begin
    pre_d = pre_q;
    idx_d = idx_q;
    if (pre_q == PRE_LAST) begin
      pre_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      pre_d = pre_q + {{(PRE_W-1){1'b0}}, 1'b1};
      idx_d = idx_q;
    end
  end

  // Output decode from the current scan index and history (registered below).
  always_comb begin
    an_n_d  = ~(4'b0001 << idx_q);
    seg_n_d = SEG_BLANK;
    dp_n_d  = ~((idx_q == 2'd0) & hold);
    // Blanking depends only on how many entries are valid, never on the value.
    if ({1'b0, idx_q} < cnt_q) begin
      seg_n_d = hex_glyph(hist_q[idx_q]);
    end else begin
      seg_n_d = SEG_BLANK;
    end
  end

  // Sequential state and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= 4'h0;
      hist_q    <= '0;
      cnt_q     <= 3'd0;
      pre_q     <= '0;
      idx_q     <= 2'd0;
      seg_n_q   <= SEG_BLANK;
      an_n_q    <= 4'b1111;
      dp_n_q    <= 1'b1;
      shift_p_q <= 1'b0;
    end else begin
      prev_q    <= value_in;
      hist_q    <= hist_d;
      cnt_q     <= cnt_d;
      pre_q     <= pre_d;
      idx_q     <= idx_d;
      seg_n_q   <= seg_n_d;
      an_n_q    <= an_n_d;
      dp_n_q    <= dp_n_d;
      shift_p_q <= shift_p_d;
    end
  end

  assign seg_n   = seg_n_q;
  assign an_n    = an_n_q;
  assign dp_n    = dp_n_q;
  assign shift_p = shift_p_q;

endmodule

// File: tb/tb_hex_history_display.sv
// Self-checking bench for hex_history_display with a small scan divider.
// The reference model keeps the history as a queue and derives the scanned
// digit from the number of clock edges since reset.
module tb_hex_history_display;

  localparam int unsigned SCAN_DIV = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] value_in;
  logic       hold;
  logic       clear;
  logic [6:0] seg_n;
  logic [3:0] an_n;
  logic       dp_n;
  logic       shift_p;

  hex_history_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .value_in(value_in),
    .hold    (hold),
    .clear   (clear),
    .seg_n   (seg_n),
    .an_n    (an_n),
    .dp_n    (dp_n),
    .shift_p (shift_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Glyph table transcribed from the display definition.
  logic [6:0] glyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state.
  int         m_hist[$];
  logic [3:0] m_prev;
  int         m_edges;

  logic [6:0] exp_seg;
  logic [3:0] exp_an;
  logic       exp_dp;
  logic       exp_shift;

  int shift_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    m_prev    = 4'h0;
    m_edges   = 0;
    exp_seg   = 7'h7F;
    exp_an    = 4'b1111;
    exp_dp    = 1'b1;
    exp_shift = 1'b0;
  endtask

  // Predict the outputs after the next rising edge and advance the model.
  task automatic model_edge();
    int idx;
    idx = (m_edges / SCAN_DIV) % 4;
    exp_an = 4'b1111;
    exp_an[idx] = 1'b0;
    exp_seg = (idx < m_hist.size()) ? glyph[m_hist[idx]] : 7'h7F;
    exp_dp = !(idx == 0 && hold);
    exp_shift = 1'b0;
    if (clear) begin
      m_hist.delete();
    end else if (value_in != m_prev && !hold) begin
      m_hist.push_front(int'(value_in));
      if (m_hist.size() > 4) void'(m_hist.pop_back());
      exp_shift = 1'b1;
    end
    m_prev = value_in;
    m_edges++;
  endtask

  task automatic check_outputs(input string phase);
    check({phase, ".seg"},   32'(seg_n),   32'(exp_seg));
    check({phase, ".an"},    32'(an_n),    32'(exp_an));
    check({phase, ".dp"},    32'(dp_n),    32'(exp_dp));
    check({phase, ".shift"}, 32'(shift_p), 32'(exp_shift));
    if (shift_p === 1'b1) shift_seen++;
  endtask

  // One cycle: called on a falling edge, drives inputs, checks at the next falling edge.
  task automatic step(input logic [3:0] v, input logic h, input logic c, input string phase);
    value_in = v;
    hold     = h;
    clear    = c;
    model_edge();
    @(negedge clk);
    check_outputs(phase);
  endtask

  task automatic steps(input int n, input logic [3:0] v, input logic h, input logic c, input string phase);
    for (int i = 0; i < n; i++) step(v, h, c, phase);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    rst_n    = 1'b0;
    value_in = 4'h0;
    hold     = 1'b0;
    clear    = 1'b0;
    model_reset();
    shift_seen = 0;

    // Outputs held at reset values while rst_n is low.
    repeat (3) begin
      @(negedge clk);
      check_outputs("in_reset");
    end
    rst_n = 1'b1;
    model_reset();

    // Idle scan with value 0: every digit blank, no shifts.
    shift_seen = 0;
    steps(4 * SCAN_DIV * 2 + 1, 4'h0, 1'b0, 1'b0, "idle_scan");
    check("idle_shifts", 32'(shift_seen), 32'd0);

    // Single change 0 -> 3.
    shift_seen = 0;
    steps(4 * SCAN_DIV + 2, 4'h3, 1'b0, 1'b0, "single");
    check("single_shifts", 32'(shift_seen), 32'd1);

    // Saturation: 1..5, each held three cycles, then a full frame.
    shift_seen = 0;
    for (int v = 1; v <= 5; v++) steps(3, 4'(v), 1'b0, 1'b0, "sat");
    steps(4 * SCAN_DIV + 1, 4'h5, 1'b0, 1'b0, "sat_frame");
    check("sat_shifts", 32'(shift_seen), 32'd5);

    // Hold: 3 -> 9 while held is lost; release with 9 stable gives no shift.
    steps(2, 4'h3, 1'b0, 1'b0, "pre_hold");
    shift_seen = 0;
    steps(2, 4'h3, 1'b1, 1'b0, "hold");
    steps(4 * SCAN_DIV + 1, 4'h9, 1'b1, 1'b0, "hold_chg");
    steps(4 * SCAN_DIV + 1, 4'h9, 1'b0, 1'b0, "hold_rel");
    check("hold_shifts", 32'(shift_seen), 32'd0);

    // Clear coinciding with a change 5 -> A.
    steps(3, 4'h5, 1'b0, 1'b0, "pre_clear");
    shift_seen = 0;
    step(4'hA, 1'b1, 1'b1, "clear_hold");
    step(4'hA, 1'b0, 1'b1, "clear");
    steps(4 * SCAN_DIV + 1, 4'hA, 1'b0, 1'b0, "post_clear");
    check("clear_shifts", 32'(shift_seen), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] v;
      logic h;
      logic c;
      v = ($urandom_range(0, 2) == 0) ? 4'(value_in) : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) v = value_in + 4'd1;
      h = ($urandom_range(0, 7) == 0);
      c = ($urandom_range(0, 31) == 0);
      step(v, h, c, "rand");
    end

    // Fill history, then reset while digit 2 is displayed.
    for (int v = 1; v <= 4; v++) step(4'(v), 1'b0, 1'b0, "fill");
    budget = 0;
    while (!(exp_an == 4'b1011 && m_hist.size() == 4) && budget < 64) begin
      step(4'h4, 1'b0, 1'b0, "seek");
      budget++;
    end
    check("seek_budget", 32'(budget < 64), 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("mid_reset");
    value_in = 4'h0;
    repeat (2) begin
      @(negedge clk);
      check_outputs("mid_reset_hold");
    end
    rst_n = 1'b1;
    shift_seen = 0;
    steps(4 * SCAN_DIV + 1, 4'h0, 1'b0, 1'b0, "after_reset");
    check("after_reset_shifts", 32'(shift_seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_history_display.md
# hex_history_display

Downstream display stage for the 4-bit nibble result produced by the register/logic stage. Drives a 4-digit common-anode seven-segment display. It keeps a history of the last four distinct values seen on its input, shown newest on digit 0, and time-multiplexes the digits with a programmable scan prescaler. All outputs are registered. Single clock domain.

## Interface
- SCAN_DIV, 50000, clock cycles each digit stays active; legal range 2..2^20
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- value_in  input  4  nibble from upstream stage; sampled every cycle
- hold  input  1  level; 1 freezes history (changes ignored)
- clear  input  1  level, synchronous; empties history
- seg_n  output  7  segments {g,f,e,d,c,b,a}, active-low
- an_n  output  4  digit anodes, active-low one-hot (bit i = digit i)
- dp_n  output  1  decimal point, active-low
- shift_p  output  1  one-cycle pulse per history shift

## Operation
- State:
  - prev_reg[3:0]: last sampled value_in.
  - hist[0..3][3:0]: history, hist[0] newest.
  - cnt_reg[2:0]: valid entries, 0..4, saturating.
  - pre_reg: prescaler, 0..SCAN_DIV-1.
  - idx_reg[1:0]: scanned digit.
- Change detect: change = (value_in != prev_reg). prev_reg <= value_in every cycle, regardless of hold. Changes during hold are therefore lost and are not replayed on release.
- Priority, per cycle:
  1. clear=1: hist all 0, cnt_reg 0, no shift, shift_p 0. Scan logic is unaffected.
  2. else if change and hold=0: hist[3]<=hist[2], hist[2]<=hist[1], hist[1]<=hist[0], hist[0]<=value_in. cnt_reg <= min(cnt_reg+1, 4). shift_p 1 next cycle.
  3. else: hold all values; shift_p 0.
- Scan:
  - pre_reg increments and wraps at SCAN_DIV-1.
  - On wrap, idx_reg increments mod 4 (3 -> 0).
- Output decode, registered:
  - an_n: bit idx_reg low, all other bits high.
  - seg_n: hex glyph of hist[idx_reg] if idx_reg < cnt_reg, else 7'h7F (blank).
  - dp_n: 0 only when idx_reg==0 and hold==1.
- Glyphs (seg_n):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Value 0 is a legitimate history entry. Blanking is controlled only by cnt_reg, never by the value.

## Timing
- Reset values, asynchronous and immediate:
  - prev_reg 0, hist 0, cnt_reg 0, pre_reg 0, idx_reg 0.
  - seg_n 7'h7F, an_n 4'b1111, dp_n 1, shift_p 0.
- First edge after reset release: an_n=1110, seg_n=7F (cnt 0).
- Output latency: one cycle from idx_reg/hist/hold to seg_n/an_n/dp_n. A shift at edge k appears on seg_n at edge k+1 if its digit is being scanned.
- Each digit is active for exactly SCAN_DIV cycles. Full frame is 4*SCAN_DIV cycles.
- shift_p: high for exactly the one cycle after the edge that performed the shift.
- value_in changing every cycle: a shift occurs every cycle, with no loss.
- At reset, prev_reg=0, so value_in=0 after release produces no shift.
- Reset mid-operation: outputs go to reset values without waiting for a clock edge. The scan restarts at digit 0.
- clear and hold asserted together: clear wins.

## Test plan
- Reset/scan, SCAN_DIV=4, value_in=0: during reset, an_n=1111, seg_n=7F, dp_n=1. After release, an_n cycles 1110,1101,1011,0111,1110… at 4 cycles each, seg_n stays 7F, no shift_p.
- Single change: value_in 0->3 and held. Expect one shift_p pulse and cnt=1. Digit 0 shows 0110000; digits 1-3 show 7F.
- Saturation: value_in 1,2,3,4,5, each held 3 cycles. Expect 5 shift_p pulses and cnt=4. Digits 0..3 show 5,4,3,2 (0010010, 0011001, 0110000, 0100100).
- Hold: hold=1, then value_in 3->9. Expect no shift_p, history unchanged, dp_n=0 only in the digit-0 slot. Drop hold with value_in still 9: no shift.
- Clear vs change: clear=1 in the same cycle value_in changes 5->A. Expect no shift_p, cnt=0, all digits blank. Release clear with A stable: no shift.
- Reset mid-scan: assert rst_n=0 while an_n=1011 and cnt=4. Outputs go to 1111/7F immediately. After release, scanning restarts at 1110 and all digits are blank.
